mult_arb: RTL and testbench

MULT_ARB -- requirements
Module: mult_arb

---
 rtl/mult_arb_pkg.sv | 5 +
 rtl/mult_arb_rr_pick.sv | 20 ++
 rtl/mult_arb.sv | 88 ++++++++
 tb/tb_mult_arb.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared FSM state encoding and default timeout for mult_arb
package mult_arb_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE} state_t;
  localparam int TMO_DEF = 4;
endpackage

// File: rtl/mult_arb_rr_pick.sv
// rr_pick: one-hot round-robin selection, searching from the slot after ptr
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] idx;
  // scan farthest-first so the nearest requester after ptr is written last and wins
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) gnt = N'(1) << idx;
    end
  end
endmodule

// File: rtl/mult_arb.sv
// mult_arb: round-robin arbiter sharing one external multiplier among N requesters
module mult_arb
  import mult_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int TMO   = TMO_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] req_a,
  input  logic [N*WIDTH-1:0] req_b,
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       done,
  output logic [2*WIDTH-1:0] res,
  output logic               err,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_busy,
  input  logic [2*WIDTH-1:0] mul_o
);
  localparam int IW = $clog2(N);
  localparam int TW = $clog2(TMO) + 1;
  state_t        state;
  logic [IW-1:0] ptr, gidx, pidx;
  logic [TW-1:0] tcnt;
  logic [N-1:0]  pick;
  rr_pick #(.N(N)) u_pick (.req(req), .ptr(ptr), .gnt(pick));
  // binary index of the picked requester, used for operand muxing and pointer update
  always_comb begin
    pidx = '0;
    for (int i = 0; i < N; i++) if (pick[i]) pidx = IW'(i);
  end
  // arbitration and multiplier handshake sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      res       <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      ptr       <= IW'(N - 1);
      gidx      <= '0;
      tcnt      <= '0;
    end else begin
      mul_start <= 1'b0;
      done      <= '0;
      err       <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          state     <= ISSUE;
          gnt       <= pick;
          gidx      <= pidx;
          mul_start <= 1'b1;
          mul_a     <= req_a[pidx*WIDTH +: WIDTH];
          mul_b     <= req_b[pidx*WIDTH +: WIDTH];
        end
        ISSUE: begin
          state <= WAIT_HI;
          tcnt  <= '0;
        end
        WAIT_HI: if (mul_busy) state <= WAIT_LO;
        else if (tcnt == TW'(TMO - 1)) begin
          err   <= 1'b1;
          gnt   <= '0;
          ptr   <= gidx;
          state <= IDLE;
        end else tcnt <= tcnt + 1'b1;
        WAIT_LO: if (!mul_busy) begin
          res   <= mul_o;
          done  <= gnt;
          state <= DONE;
        end
        DONE: begin
          ptr   <= gidx;
          gnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_arb.sv
// tb_mult_arb: directed self-checking bench for mult_arb with a standard multiplier model
module tb_mult_arb;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [3:0]  gnt, done;
  logic [15:0] res, mul_o;
  logic        err, mul_start, mul_busy;
  logic [7:0]  mul_a, mul_b;
  logic        dead = 1'b0;
  logic [1:0]  st;
  int          nvec = 0, nerr = 0;
  int          lat, starts, gap;
  logic [3:0]  g;
  logic        saw;
  logic [15:0] prod [4] = '{16'd20, 16'd33, 16'd48, 16'd65};

  mult_arb #(.N(4), .WIDTH(8), .TMO(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .done(done), .res(res), .err(err), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_busy(mul_busy), .mul_o(mul_o)
  );

  always #5 clk = ~clk;

  // multiplier: busy one cycle after start for two cycles, product valid two cycles after start
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st    <= '0;
      mul_o <= '0;
    end else begin
      st <= {st[0], mul_start & ~dead};
      if (st[0]) mul_o <= mul_a * mul_b;
    end
  assign mul_busy = |st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(output int n, output logic [3:0] gg);
    n = -1;
    gg = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (gnt != 0) begin
        n = i;
        gg = gnt;
        break;
      end
    end
  endtask

  task automatic wait_done(output int n, output int s);
    n = -1;
    s = int'(mul_start);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      s += int'(mul_start);
      if (done != 0) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_res", res, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // single request 3*5
    req_a[7:0] = 8'd3;
    req_b[7:0] = 8'd5;
    req = 4'b0001;
    wait_gnt(lat, g);
    chk("single_gnt", g, 4'b0001);
    chk("single_start", mul_start, 1);
    chk("single_opa", mul_a, 3);
    chk("single_opb", mul_b, 5);
    wait_done(lat, starts);
    chk("single_lat", lat, 4);
    chk("single_done", done, 4'b0001);
    chk("single_res", res, 15);
    chk("single_starts", starts, 1);
    req = 4'b0000;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("gnt_clear", gnt, 0);
    // contention from a fresh pointer
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_a[8*i +: 8] = 8'(i + 2);
      req_b[8*i +: 8] = 8'(i + 10);
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(gap, g);
      chk("rr_gnt", g, 32'd1 << (k % 4));
      if (k > 0) chk("rr_gap", gap, 2);
      wait_done(lat, starts);
      chk("rr_done", done, 32'd1 << (k % 4));
      chk("rr_res", res, prod[k % 4]);
    end
    req = 4'b0000;
    // maximum operands
    req_a[23:16] = 8'd255;
    req_b[23:16] = 8'd255;
    req = 4'b0100;
    wait_gnt(lat, g);
    chk("max_gnt", g, 4'b0100);
    wait_done(lat, starts);
    chk("max_done", done, 4'b0100);
    chk("max_res", res, 16'hFE01);
    req = 4'b0000;
    // timeout on requester 3, then requester 0 served
    dead = 1'b1;
    req_a[7:0] = 8'd6;
    req_b[7:0] = 8'd7;
    req = 4'b1001;
    wait_gnt(lat, g);
    chk("tmo_gnt", g, 4'b1000);
    saw = 1'b0;
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      saw |= (done != 0);
      if (err) begin
        lat = i;
        break;
      end
    end
    chk("tmo_lat", lat, 5);
    chk("tmo_gnt_clr", gnt, 0);
    chk("tmo_nodone", saw, 0);
    dead = 1'b0;
    @(negedge clk);
    chk("tmo_pulse", err, 0);
    chk("tmo_next", gnt, 4'b0001);
    wait_done(lat, starts);
    chk("tmo_next_res", res, 42);
    req = 4'b0000;
    // reset during WAIT_LO
    req_a[7:0] = 8'd3;
    req_b[7:0] = 8'd5;
    req = 4'b0001;
    wait_gnt(lat, g);
    chk("abort_gnt", g, 4'b0001);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    req = 4'b1111;
    #1;
    chk("abort_gnt0", gnt, 0);
    chk("abort_done0", done, 0);
    chk("abort_err0", err, 0);
    chk("abort_res0", res, 0);
    chk("abort_start0", mul_start, 0);
    chk("abort_mul_a0", mul_a, 0);
    chk("abort_mul_b0", mul_b, 0);
    @(negedge clk);
    chk("abort_nodone", done, 0);
    rst_n = 1'b1;
    wait_gnt(lat, g);
    chk("abort_winner", g, 4'b0001);
    wait_done(lat, starts);
    chk("abort_res", res, 15);
    req = 4'b0000;
    // operand and request changes after grant are ignored
    req_a[31:24] = 8'd12;
    req_b[31:24] = 8'd13;
    req = 4'b1000;
    wait_gnt(lat, g);
    chk("opchg_gnt", g, 4'b1000);
    @(negedge clk);
    req_a[31:24] = 8'd99;
    req = 4'b0000;
    wait_done(lat, starts);
    chk("opchg_done", done, 4'b1000);
    chk("opchg_res", res, 156);
    chk("opchg_mul_a", mul_a, 12);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
